// File: rtl/dcache_controller_if.sv
`default_nettype none
// ============================================================================
// dcache_controller_if
//   CPU-side and memory-side signal bundle for the data-cache controller.
// Revision: 1.0
// ============================================================================
interface dcache_controller_if #(
  parameter int LINE_BITS = 256
);
  logic                 start_i;
  logic                 cpu_req_i;
  logic                 cpu_write_i;
  logic [31:0]          cpu_addr_i;
  logic [31:0]          cpu_data_i;
  logic [31:0]          cpu_data_o;
  logic                 cpu_stall_o;
  logic                 mem_req_o;
  logic                 mem_write_o;
  logic [31:0]          mem_addr_o;
  logic [LINE_BITS-1:0] mem_data_o;
  logic [LINE_BITS-1:0] mem_data_i;
  logic                 mem_ack_i;

  modport slave (
    input  start_i, cpu_req_i, cpu_write_i, cpu_addr_i, cpu_data_i,
    input  mem_data_i, mem_ack_i,
    output cpu_data_o, cpu_stall_o, mem_req_o, mem_write_o, mem_addr_o, mem_data_o
  );

  modport master (
    output start_i, cpu_req_i, cpu_write_i, cpu_addr_i, cpu_data_i,
    output mem_data_i, mem_ack_i,
    input  cpu_data_o, cpu_stall_o, mem_req_o, mem_write_o, mem_addr_o, mem_data_o
  );
endinterface
`default_nettype wire

// File: rtl/dcache_controller.sv
`default_nettype none
// ============================================================================
// dcache_controller
//   Direct-mapped write-back/write-allocate data cache with refill/writeback FSM.
// Revision: 1.0
// ============================================================================
module dcache_controller #(
  parameter int LINES     = 16,
  parameter int LINE_BITS = 256
) (
  input  wire logic          clk_i,
  input  wire logic          rst_i,
  dcache_controller_if.slave bus
);
  localparam int IDX_W = $clog2(LINES);
  localparam int OFF_W = $clog2(LINE_BITS / 8);
  localparam int WRD_W = $clog2(LINE_BITS / 32);
  localparam int TAG_W = 32 - IDX_W - OFF_W;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WRITEBACK = 2'd1,
    ST_ALLOCATE  = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic                 mem_req_q, mem_req_d;
  logic                 mem_write_q, mem_write_d;
  logic [31:0]          mem_addr_q, mem_addr_d;
  logic [LINE_BITS-1:0] mem_data_q, mem_data_d;
  logic [LINES-1:0]     valid_q, valid_d;
  logic [LINES-1:0]     dirty_q, dirty_d;
  logic [TAG_W-1:0]     tag_q  [LINES];
  logic [LINE_BITS-1:0] data_q [LINES];

  logic [TAG_W-1:0] addr_tag;
  logic [IDX_W-1:0] addr_idx;
  logic [WRD_W-1:0] addr_word;
  logic [WRD_W+4:0] word_lsb;
  logic [31:0]      alloc_addr;
  logic             lookup, hit, miss, in_idle, ack_seen, store_en, fill_en;
  logic             unused_addr_bits;

  assign addr_tag         = bus.cpu_addr_i[31 -: TAG_W];
  assign addr_idx         = bus.cpu_addr_i[OFF_W +: IDX_W];
  assign addr_word        = bus.cpu_addr_i[2 +: WRD_W];
  assign word_lsb         = {addr_word, 5'd0};
  assign unused_addr_bits = ^bus.cpu_addr_i[1:0];
  assign alloc_addr       = {addr_tag, addr_idx, {OFF_W{1'b0}}};

  assign lookup   = bus.start_i & bus.cpu_req_i;
  assign hit      = lookup & valid_q[addr_idx] & (tag_q[addr_idx] == addr_tag);
  assign miss     = lookup & ~hit;
  assign in_idle  = (state_q == ST_IDLE);
  assign ack_seen = mem_req_q & bus.mem_ack_i;
  assign store_en = in_idle & hit & bus.cpu_write_i;
  assign fill_en  = (state_q == ST_ALLOCATE) & ack_seen;

  assign bus.cpu_data_o  = data_q[addr_idx][word_lsb +: 32];
  assign bus.cpu_stall_o = ~in_idle | miss;
  assign bus.mem_req_o   = mem_req_q;
  assign bus.mem_write_o = mem_write_q;
  assign bus.mem_addr_o  = mem_addr_q;
  assign bus.mem_data_o  = mem_data_q;

  // Memory-port outputs are registered: each transition loads the values for the next state.
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_data_d  = mem_data_q;
    valid_d     = valid_q;
    dirty_d     = dirty_q;
    case (state_q)
      ST_IDLE: begin
        if (store_en) begin
          dirty_d[addr_idx] = 1'b1;
        end
        if (miss) begin
          mem_req_d = 1'b1;
          if (valid_q[addr_idx] & dirty_q[addr_idx]) begin
            state_d     = ST_WRITEBACK;
            mem_write_d = 1'b1;
            mem_addr_d  = {tag_q[addr_idx], addr_idx, {OFF_W{1'b0}}};
            mem_data_d  = data_q[addr_idx];
          end else begin
            state_d     = ST_ALLOCATE;
            mem_write_d = 1'b0;
            mem_addr_d  = alloc_addr;
            mem_data_d  = '0;
          end
        end
      end
      ST_WRITEBACK: begin
        if (ack_seen) begin
          state_d     = ST_ALLOCATE;
          mem_write_d = 1'b0;
          mem_addr_d  = alloc_addr;
          mem_data_d  = '0;
        end
      end
      ST_ALLOCATE: begin
        if (ack_seen) begin
          state_d           = ST_IDLE;
          mem_req_d         = 1'b0;
          mem_write_d       = 1'b0;
          mem_addr_d        = '0;
          mem_data_d        = '0;
          valid_d[addr_idx] = 1'b1;
          dirty_d[addr_idx] = 1'b0;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        mem_req_d   = 1'b0;
        mem_write_d = 1'b0;
        mem_addr_d  = '0;
        mem_data_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      mem_req_q   <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
      valid_q     <= '0;
      dirty_q     <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_data_q  <= mem_data_d;
      valid_q     <= valid_d;
      dirty_q     <= dirty_d;
    end
  end

  // Tag and data contents need no reset; the valid bits qualify them.
  always_ff @(posedge clk_i) begin
    if (!rst_i && fill_en) begin
      tag_q[addr_idx]  <= addr_tag;
      data_q[addr_idx] <= bus.mem_data_i;
    end else if (!rst_i && store_en) begin
      data_q[addr_idx][word_lsb +: 32] <= bus.cpu_data_i;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_dcache_controller.sv
`default_nettype none
// ============================================================================
// tb_dcache_controller
//   Directed scoreboard bench: stimulus queues expected memory requests and
//   load data; a monitor compares them whenever the controller presents them.
// Revision: 1.0
// ============================================================================
module tb_dcache_controller;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dcache_controller_if #(.LINE_BITS(256)) bus ();
  dcache_controller #(.LINES(16), .LINE_BITS(256)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  typedef struct {
    logic         wr;
    logic [31:0]  addr;
    logic [255:0] data;
  } mem_exp_t;

  typedef struct {
    int           delay;
    logic [255:0] line;
  } resp_t;

  mem_exp_t    exp_mem_q[$];
  logic [31:0] exp_load_q[$];
  resp_t       resp_q[$];
  int errors = 0;
  int checks = 0;
  int stray_req = 0;
  int stray_done = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check256(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: a memory request is new when req rises or its direction/address changes.
  logic        prev_req = 1'b0;
  logic        prev_wr = 1'b0;
  logic [31:0] prev_addr = '0;
  always @(negedge clk) begin : monitor
    mem_exp_t    e;
    logic [31:0] el;
    if (!rst) begin
      if (bus.mem_req_o && (!prev_req || bus.mem_write_o !== prev_wr || bus.mem_addr_o !== prev_addr)) begin
        if (exp_mem_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL mem_req: unexpected request addr %h write %b, expected none", bus.mem_addr_o, bus.mem_write_o);
        end else begin
          e = exp_mem_q.pop_front();
          check32("mem_write", {31'd0, bus.mem_write_o}, {31'd0, e.wr});
          check32("mem_addr", bus.mem_addr_o, e.addr);
          if (e.wr) check256("mem_data", bus.mem_data_o, e.data);
        end
      end
      if (bus.start_i && bus.cpu_req_i && !bus.cpu_write_i && !bus.cpu_stall_o) begin
        if (exp_load_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL load_data: unexpected load completion addr %h data %h, expected none", bus.cpu_addr_i, bus.cpu_data_o);
        end else begin
          el = exp_load_q.pop_front();
          check32("load_data", bus.cpu_data_o, el);
        end
      end
    end
    prev_req  = bus.mem_req_o;
    prev_wr   = bus.mem_write_o;
    prev_addr = bus.mem_addr_o;
  end

  // Memory model: acks the k-th request 'delay' cycles after req is first seen.
  initial begin : responder
    bit    busy;
    int    cnt;
    resp_t r;
    busy = 1'b0;
    cnt  = 0;
    r.delay = 1;
    r.line  = '0;
    bus.mem_ack_i  = 1'b0;
    bus.mem_data_i = '0;
    forever begin
      @(negedge clk);
      bus.mem_ack_i = 1'b0;
      if (rst) begin
        busy = 1'b0;
      end else if (bus.mem_req_o) begin
        if (!busy) begin
          busy = 1'b1;
          cnt  = 0;
          if (resp_q.size() > 0) r = resp_q.pop_front();
          else begin
            r.delay = 1;
            r.line  = '0;
          end
        end else begin
          cnt++;
        end
        if (cnt >= r.delay) begin
          bus.mem_ack_i  = 1'b1;
          bus.mem_data_i = r.line;
          busy = 1'b0;
        end
      end else begin
        busy = 1'b0;
        if (stray_done != stray_req) begin
          bus.mem_ack_i  = 1'b1;
          bus.mem_data_i = '1;
          stray_done++;
        end
      end
    end
  end

  task automatic access(input logic wr, input logic [31:0] a, input logic [31:0] d, output int sc);
    @(posedge clk);
    #1;
    bus.cpu_req_i   = 1'b1;
    bus.cpu_write_i = wr;
    bus.cpu_addr_i  = a;
    bus.cpu_data_i  = d;
    sc = 0;
    forever begin
      @(negedge clk);
      if (!bus.cpu_stall_o) break;
      sc++;
      if (sc > 50) begin
        checks++;
        errors++;
        $display("FAIL access_timeout: addr %h still stalled after %0d cycles, required completion", a, sc);
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.cpu_req_i   = 1'b0;
    bus.cpu_write_i = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int           sc;
    logic [255:0] line_a, line_b, line_c, line_d, line_e, wb;

    bus.start_i     = 1'b1;
    bus.cpu_req_i   = 1'b0;
    bus.cpu_write_i = 1'b0;
    bus.cpu_addr_i  = '0;
    bus.cpu_data_i  = '0;

    line_a = '0; line_a[31:0] = 32'hDEADBEEF; line_a[63:32] = 32'hA0A00001; line_a[255:224] = 32'hA0A00007;
    line_b = '0; line_b[31:0] = 32'hCAFEF00D; line_b[63:32] = 32'hB0B00001;
    line_c = '0; line_c[95:64] = 32'h22222222; line_c[127:96] = 32'h33333333;
    line_d = '0; line_d[31:0] = 32'hD0D0D0D0;
    line_e = '0; line_e[31:0] = 32'hE0E0E0E0;

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check32("reset_stall", {31'd0, bus.cpu_stall_o}, 32'd0);
    check32("reset_mem_req", {31'd0, bus.mem_req_o}, 32'd0);
    check32("reset_mem_addr", bus.mem_addr_o, 32'd0);

    // Clean load miss, ack three cycles after req.
    exp_mem_q.push_back('{1'b0, 32'h40, '0});
    resp_q.push_back('{3, line_a});
    exp_load_q.push_back(32'hDEADBEEF);
    access(1'b0, 32'h40, 32'h0, sc);
    check32("clean_miss_stall_cycles", sc, 32'd5);

    // Hit store then hit loads.
    access(1'b1, 32'h44, 32'h12345678, sc);
    check32("store_hit_stall", sc, 32'd0);
    exp_load_q.push_back(32'h12345678);
    access(1'b0, 32'h44, 32'h0, sc);
    check32("load_hit_stall", sc, 32'd0);
    exp_load_q.push_back(32'hDEADBEEF);
    access(1'b0, 32'h40, 32'h0, sc);

    // Conflict miss on a dirty line: writeback then refill.
    wb = line_a; wb[63:32] = 32'h12345678;
    exp_mem_q.push_back('{1'b1, 32'h40, wb});
    exp_mem_q.push_back('{1'b0, 32'h240, '0});
    resp_q.push_back('{2, '0});
    resp_q.push_back('{2, line_b});
    exp_load_q.push_back(32'hCAFEF00D);
    access(1'b0, 32'h240, 32'h0, sc);
    check32("dirty_miss_stall_cycles", sc, 32'd7);

    // Store miss to an invalid line: refill only, then the replayed store dirties it.
    exp_mem_q.push_back('{1'b0, 32'h80, '0});
    resp_q.push_back('{1, line_c});
    access(1'b1, 32'h8C, 32'hA5A5A5A5, sc);
    check32("store_miss_stall_cycles", sc, 32'd3);
    exp_load_q.push_back(32'hA5A5A5A5);
    access(1'b0, 32'h8C, 32'h0, sc);
    exp_load_q.push_back(32'h22222222);
    access(1'b0, 32'h88, 32'h0, sc);
    wb = line_c; wb[127:96] = 32'hA5A5A5A5;
    exp_mem_q.push_back('{1'b1, 32'h80, wb});
    exp_mem_q.push_back('{1'b0, 32'h280, '0});
    resp_q.push_back('{1, '0});
    resp_q.push_back('{1, line_d});
    exp_load_q.push_back(32'hD0D0D0D0);
    access(1'b0, 32'h280, 32'h0, sc);
    check32("evict_stall_cycles", sc, 32'd5);

    // start_i low: requests ignored, arrays untouched.
    @(posedge clk);
    #1;
    bus.start_i = 1'b0; bus.cpu_req_i = 1'b1; bus.cpu_write_i = 1'b1;
    bus.cpu_addr_i = 32'h244; bus.cpu_data_i = 32'hBAD0BAD0;
    @(negedge clk);
    check32("nostart_store_stall", {31'd0, bus.cpu_stall_o}, 32'd0);
    check32("nostart_store_mem_req", {31'd0, bus.mem_req_o}, 32'd0);
    @(posedge clk);
    #1;
    bus.cpu_write_i = 1'b0; bus.cpu_addr_i = 32'h400;
    @(negedge clk);
    check32("nostart_miss_stall", {31'd0, bus.cpu_stall_o}, 32'd0);
    check32("nostart_miss_mem_req", {31'd0, bus.mem_req_o}, 32'd0);
    check32("idle_mem_addr", bus.mem_addr_o, 32'd0);
    @(posedge clk);
    #1;
    bus.cpu_req_i = 1'b0; bus.start_i = 1'b1;
    exp_load_q.push_back(32'hB0B00001);
    access(1'b0, 32'h244, 32'h0, sc);
    check32("nostart_then_hit_stall", sc, 32'd0);

    // Reset during ALLOCATE, stray ack afterwards, then the same load misses again.
    exp_mem_q.push_back('{1'b0, 32'h300, '0});
    resp_q.push_back('{1000, '0});
    @(posedge clk);
    #1;
    bus.cpu_req_i = 1'b1; bus.cpu_write_i = 1'b0; bus.cpu_addr_i = 32'h300;
    repeat (3) @(negedge clk);
    check32("alloc_stall", {31'd0, bus.cpu_stall_o}, 32'd1);
    check32("alloc_mem_req", {31'd0, bus.mem_req_o}, 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1; bus.cpu_req_i = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check32("post_reset_mem_req", {31'd0, bus.mem_req_o}, 32'd0);
    check32("post_reset_stall", {31'd0, bus.cpu_stall_o}, 32'd0);
    stray_req++;
    repeat (3) @(negedge clk);
    check32("stray_ack_mem_req", {31'd0, bus.mem_req_o}, 32'd0);
    check32("stray_ack_stall", {31'd0, bus.cpu_stall_o}, 32'd0);
    exp_mem_q.push_back('{1'b0, 32'h300, '0});
    resp_q.push_back('{2, line_e});
    exp_load_q.push_back(32'hE0E0E0E0);
    access(1'b0, 32'h300, 32'h0, sc);
    check32("remiss_stall_cycles", sc, 32'd4);

    repeat (3) @(negedge clk);
    check32("pending_mem_expectations", exp_mem_q.size(), 32'd0);
    check32("pending_load_expectations", exp_load_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/dcache_controller.md
# dcache_controller

Direct-mapped, write-back, write-allocate data-cache controller between the MEM stage and off-chip data memory. It owns the tag, valid, dirty and data arrays and sequences line refills and writebacks over a single-outstanding request/ack memory port. It generates `cpu_stall_o`, which feeds `mem_stall_i` of every pipeline register (IF/ID through MEM/WB), freezing the pipeline while a miss is serviced.

## Interface

Parameters:
- `LINES`, 16: number of cache lines; index width is log2(LINES) = 4.
- `LINE_BITS`, 256: line size in bits (32 bytes, 8 words).

Ports:
- `clk_i` in 1: single clock; all state updates on posedge.
- `rst_i` in 1: reset, synchronous, active-high.
- `start_i` in 1: CPU running; when low, `cpu_req_i` is ignored.
- `cpu_req_i` in 1: MEM-stage load or store valid.
- `cpu_write_i` in 1: 1 = store, 0 = load.
- `cpu_addr_i` in 32: byte address, word-aligned.
- `cpu_data_i` in 32: store data.
- `cpu_data_o` out 32: load data; valid only in a cycle with `cpu_req_i`=1 and `cpu_stall_o`=0.
- `cpu_stall_o` out 1: freeze pipeline.
- `mem_req_o` out 1: memory request.
- `mem_write_o` out 1: 1 = writeback, 0 = refill read.
- `mem_addr_o` out 32: line-aligned address (bits [4:0] = 0).
- `mem_data_o` out 256: writeback line.
- `mem_data_i` in 256: refill line; valid in the `mem_ack_i` cycle.
- `mem_ack_i` in 1: one-cycle completion pulse.

## Operation

- Address split: tag = [31:9] (23 b), index = [8:5], word = [4:2]; bits [1:0] are ignored.
- Per line: valid, dirty, tag[22:0], data[255:0]. Word w occupies data bits [32w+31:32w].
- hit = `start_i` & `cpu_req_i` & valid[index] & (tag[index] == addr tag).
- FSM states: IDLE, WRITEBACK, ALLOCATE.
- IDLE:
  - Hit load: `cpu_data_o` is the selected word, combinationally.
  - Hit store: at the clock edge, the selected word is written with `cpu_data_i` and dirty is set to 1.
  - Miss (`start_i` & `cpu_req_i` & ~hit): if the victim is valid and dirty, go to WRITEBACK; otherwise go to ALLOCATE.
- WRITEBACK:
  - `mem_req_o`=1, `mem_write_o`=1.
  - `mem_addr_o` = {victim tag, index, 5'b0}.
  - `mem_data_o` = victim line.
  - On `mem_ack_i`: go to ALLOCATE.
- ALLOCATE:
  - `mem_req_o`=1, `mem_write_o`=0.
  - `mem_addr_o` = {cpu tag, index, 5'b0}.
  - On `mem_ack_i`: line = `mem_data_i`, tag = cpu tag, valid = 1, dirty = 0; go to IDLE.
- Replay: back in IDLE the held access now hits and completes as a normal hit. A store miss therefore completes as refill followed by a hit store, which sets dirty.
- Stall logic: `cpu_stall_o` = (state != IDLE) | (`start_i` & `cpu_req_i` & ~hit).
- Held inputs: `cpu_addr_i`, `cpu_write_i` and `cpu_data_i` are held stable by the frozen pipeline while stalled. The controller does not latch them, except that the victim tag comes from the array.
- Idle outputs: in IDLE, `mem_req_o`=0, and `mem_addr_o` and `mem_data_o` are 0.
- `start_i`=0: no lookup, no array writes, `cpu_stall_o`=0 in IDLE. An in-flight WRITEBACK or ALLOCATE still runs to its ack.

## Timing

- Reset, at the edge with `rst_i`=1:
  - state = IDLE.
  - All valid and dirty bits = 0; tags and data are don't-care.
  - `mem_req_o`=0, `cpu_stall_o`=0 (absent a request).
- Reset mid-operation: any in-flight request is abandoned the next cycle, with no array update. A late `mem_ack_i` arriving in IDLE is ignored.
- Hit latency: 0 cycles, combinational read; a store commits at the same edge.
- Memory handshake:
  - `mem_req_o` rises in the first cycle of WRITEBACK/ALLOCATE.
  - Address, data and `mem_write_o` stay constant until the ack cycle.
  - `mem_ack_i` is sampled only while `mem_req_o`=1; an ack while `mem_req_o`=0 is ignored.
  - Write-to-read transition: the request stays high into ALLOCATE, with address and `mem_write_o` changing at that edge.
- Clean miss, with ack N cycles after req rises (ack in ALLOCATE cycle N, counting from 0):
  - Stall is high for cycles 0 (IDLE detect) through N+1 (last ALLOCATE cycle).
  - The access completes in the IDLE cycle after the ack.
  - Total: N+2 stall cycles.
- Dirty miss: adds (writeback ack latency + 1) cycles.
- Simultaneous events: `rst_i` overrides ack and store. An ack in the same cycle as a state entry is legal only from the second cycle of that state; memory must not ack before seeing `mem_req_o`.

## Test plan

- Reset, then a load to 0x0000_0040 → `cpu_stall_o`=1 immediately; `mem_req_o`=1, `mem_write_o`=0, `mem_addr_o`=0x40. With ack 3 cycles later carrying line word0 = 0xDEADBEEF, stall drops the cycle after the ack and `cpu_data_o`=0xDEADBEEF.
- Store 0x1234_5678 to 0x44 after that fill → no stall. A load of 0x44 returns 0x12345678 and the line's dirty bit = 1.
- Load 0x0000_0240 (same index 2, different tag) → WRITEBACK first: `mem_write_o`=1, `mem_addr_o`=0x40, `mem_data_o` word1 = 0x12345678. After its ack, ALLOCATE at 0x240, then the load completes.
- Store miss to a clean line → refill read only (no writeback); the stored word is readable afterward and dirty = 1.
- `start_i`=0 with `cpu_req_i`=1 → `cpu_stall_o`=0, `mem_req_o`=0, and arrays unchanged.
- Assert `rst_i` during ALLOCATE before the ack → `mem_req_o`=0 the next cycle, state IDLE. A following ack is ignored, and the same load misses again.
